// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin burst arbiter sharing the write port of one synchronous FIFO
// among NUM_REQ producers. One producer is granted at a time for up to
// BURST_LEN accepted beats. A write is issued only while the FIFO is not full,
// so the FIFO can never overflow. Every burst is followed by exactly one idle
// cycle, in which the next grantee is chosen.
//
// Optional feature (compile-time macro FIFO_WR_ARB_STALL_CNT_EN):
//   adds stall_cnt_o, a saturating 16-bit count of burst cycles spent stalled
//   on a full FIFO while the grantee is requesting. Cleared only by reset.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   req_i         per-producer request/valid (data held while high)
//   data_i        producer data, slice k = data_i[k*DATA_WIDTH +: DATA_WIDTH]
//   gnt_o         registered one-hot grant, zero when idle
//   ack_o         combinational per-producer beat-accepted strobe
//   gnt_idx_o     registered grantee index, holds its value when idle
//   busy_o        registered, high while a burst is in progress
//   fifo_full_i   FIFO full flag
//   fifo_wr_en_o  FIFO write enable
//   fifo_wdata_o  FIFO write data (grantee's slice)
//   stall_cnt_o   (macro only) saturating full-stall cycle counter
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 12,
  parameter int BURST_LEN  = 4,
  parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [IDX_WIDTH-1:0]          gnt_idx_o,
  output logic                          busy_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wdata_o
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt_o
`endif
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_WIDTH-1:0] gnt_idx_q, gnt_idx_d;
  logic                 busy_q, busy_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;
  logic [IDX_WIDTH-1:0] last_ptr_q, last_ptr_d;

  // Round-robin search result
  logic                 sel_found;
  logic [IDX_WIDTH-1:0] sel_idx;
  int                   cand;

  // Grantee's request; gnt_q is one-hot or zero so a reduction OR suffices
  logic                 req_g;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Beat acceptance: only the grantee, only while it requests, only when
  // the FIFO has room.
  assign ack_o        = gnt_q & req_i & {NUM_REQ{~fifo_full_i}};
  assign fifo_wr_en_o = |ack_o;
  assign req_g        = |(gnt_q & req_i);

  // Write data mux driven purely from the index; the compare-based mux keeps
  // out-of-range index values (non power-of-two NUM_REQ) well defined.
  always_comb begin
    fifo_wdata_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx_q == IDX_WIDTH'(k)) begin
        fifo_wdata_o = data_arr[k];
      end
    end
  end

  // Search from last_ptr+1 upward with an explicit modulo wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!sel_found && req_i[IDX_WIDTH'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    busy_d     = busy_q;
    beat_cnt_d = beat_cnt_q;
    last_ptr_d = last_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          gnt_idx_d      = sel_idx;
          beat_cnt_d     = 8'd0;
          busy_d         = 1'b1;
          state_d        = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!req_g || (!fifo_full_i && beat_cnt_q == 8'(BURST_LEN-1))) begin
          // Release: producer dropped out, or its final beat goes out now
          gnt_d      = '0;
          busy_d     = 1'b0;
          last_ptr_d = gnt_idx_q;
          state_d    = ST_IDLE;
        end else if (!fifo_full_i) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        // Otherwise stalled on full: hold everything, no timeout.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      busy_q     <= 1'b0;
      beat_cnt_q <= 8'd0;
      last_ptr_q <= IDX_WIDTH'(NUM_REQ-1);
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      busy_q     <= busy_d;
      beat_cnt_q <= beat_cnt_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = gnt_idx_q;
  assign busy_o    = busy_q;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_inc;

  assign stall_inc = (state_q == ST_BURST) && req_g && fifo_full_i;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=12, BURST_LEN=4).
// A table of per-cycle vectors covers single-producer bursts, early drop and
// full stall; hand-written sequences cover round-robin rotation, asynchronous
// reset mid-burst, and integration with a 16-deep FIFO model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 4 time
// units after the edge, before the next one.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [47:0] data;
  logic        full;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [1:0]  idx;
  logic        busy;
  logic        wr;
  logic [11:0] wdata;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(12), .BURST_LEN(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .data_i       (data),
    .gnt_o        (gnt),
    .ack_o        (ack),
    .gnt_idx_o    (idx),
    .busy_o       (busy),
    .fifo_full_i  (full),
    .fifo_wr_en_o (wr),
    .fifo_wdata_o (wdata)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  typedef struct {
    bit          rst;    // apply reset before this row
    logic [3:0]  req;
    logic        full;
    logic [47:0] data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        wr;
    logic [11:0] wdata;  // compared only when wr is expected
    logic        busy;
    logic [1:0]  idx;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit r, logic [3:0] rq, logic f,
                              logic [11:0] d3, logic [11:0] d2,
                              logic [11:0] d1, logic [11:0] d0,
                              logic [3:0] g, logic [3:0] a, logic w,
                              logic [11:0] wd, logic b, logic [1:0] ix);
    vec_t v;
    v.rst = r; v.req = rq; v.full = f; v.data = {d3, d2, d1, d0};
    v.gnt = g; v.ack = a; v.wr = w; v.wdata = wd; v.busy = b; v.idx = ix;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Enters at posedge+1, leaves at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    full  = 1'b0;
    data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {60'h0, gnt, busy, wr, idx[0]} >> 0,
        {60'h0, 4'b0000, 1'b0, 1'b0, 1'b0});
    chk("reset_idx", {62'h0, idx}, 64'h0);
    rst_n = 1'b1;
  endtask

  // FIFO model state for integration
  int          sent[4];
  int          fcnt;
  int          n_wr;
  logic [11:0] fmem[16];
  bit          ovf, inv_bad, hold_bad;
  logic        pend_wr;
  logic [11:0] pend_data;
  logic [3:0]  pend_ack;
  logic [3:0]  held;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    full  = 1'b0;
    data  = '0;
    @(posedge clk);
    #1;

    // ---------------- Table ----------------
    // A: single producer 1, two bursts (4 + 2 beats) with one idle cycle
    vq.push_back(mk(1, 4'b0010, 0, 0, 0, 12'h0A1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0010, 0, 0, 0, 12'h0A1, 0, 4'b0010, 4'b0010, 1, 12'h0A1, 1, 1));
    vq.push_back(mk(0, 4'b0010, 0, 0, 0, 12'h0A2, 0, 4'b0010, 4'b0010, 1, 12'h0A2, 1, 1));
    vq.push_back(mk(0, 4'b0010, 0, 0, 0, 12'h0A3, 0, 4'b0010, 4'b0010, 1, 12'h0A3, 1, 1));
    vq.push_back(mk(0, 4'b0010, 0, 0, 0, 12'h0A4, 0, 4'b0010, 4'b0010, 1, 12'h0A4, 1, 1));
    vq.push_back(mk(0, 4'b0010, 0, 0, 0, 12'h0A5, 0, 4'b0000, 4'b0000, 0, 0, 0, 1));
    vq.push_back(mk(0, 4'b0010, 0, 0, 0, 12'h0A5, 0, 4'b0010, 4'b0010, 1, 12'h0A5, 1, 1));
    vq.push_back(mk(0, 4'b0010, 0, 0, 0, 12'h0A6, 0, 4'b0010, 4'b0010, 1, 12'h0A6, 1, 1));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0,       0, 4'b0010, 4'b0000, 0, 0, 1, 1));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0,       0, 4'b0000, 4'b0000, 0, 0, 0, 1));
    // C: producer 2 drops after 1 beat, producer 3 next
    vq.push_back(mk(1, 4'b1100, 0, 12'h0C3, 12'h0C2, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b1100, 0, 12'h0C3, 12'h0C2, 0, 0, 4'b0100, 4'b0100, 1, 12'h0C2, 1, 2));
    vq.push_back(mk(0, 4'b1000, 0, 12'h0C3, 12'h0C2, 0, 0, 4'b0100, 4'b0000, 0, 0, 1, 2));
    vq.push_back(mk(0, 4'b1000, 0, 12'h0C3, 12'h0C2, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 2));
    vq.push_back(mk(0, 4'b1000, 0, 12'h0C3, 12'h0C2, 0, 0, 4'b1000, 4'b1000, 1, 12'h0C3, 1, 3));
    // D: producer 2 drops after 1 beat, wrap to producer 0
    vq.push_back(mk(1, 4'b0100, 0, 0, 12'h0D2, 0, 12'h0D0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0100, 0, 0, 12'h0D2, 0, 12'h0D0, 4'b0100, 4'b0100, 1, 12'h0D2, 1, 2));
    vq.push_back(mk(0, 4'b0001, 0, 0, 12'h0D2, 0, 12'h0D0, 4'b0100, 4'b0000, 0, 0, 1, 2));
    vq.push_back(mk(0, 4'b0001, 0, 0, 12'h0D2, 0, 12'h0D0, 4'b0000, 4'b0000, 0, 0, 0, 2));
    vq.push_back(mk(0, 4'b0001, 0, 0, 12'h0D2, 0, 12'h0D0, 4'b0001, 4'b0001, 1, 12'h0D0, 1, 0));
    // B: full stall for 5 cycles after 2 beats, then 2 more beats
    vq.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 12'h0B1, 4'b0000, 4'b0000, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 12'h0B1, 4'b0001, 4'b0001, 1, 12'h0B1, 1, 0));
    vq.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 12'h0B2, 4'b0001, 4'b0001, 1, 12'h0B2, 1, 0));
    for (int s = 0; s < 5; s++) begin
      vq.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 12'h0B3, 4'b0001, 4'b0000, 0, 0, 1, 0));
    end
    vq.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 12'h0B3, 4'b0001, 4'b0001, 1, 12'h0B3, 1, 0));
    vq.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 12'h0B4, 4'b0001, 4'b0001, 1, 12'h0B4, 1, 0));
    vq.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 12'h0B5, 4'b0000, 4'b0000, 0, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      logic [63:0] act, exp;
      v = vq[i];
      if (v.rst) do_reset();
      req  = v.req;
      full = v.full;
      data = v.data;
      #3;
      act = {38'h0, gnt, ack, wr, busy, idx, (v.wr ? wdata : 12'h000)};
      exp = {38'h0, v.gnt, v.ack, v.wr, v.busy, v.idx, (v.wr ? v.wdata : 12'h000)};
      $display("row %0d: req=%b full=%b gnt=%b ack=%b wr=%b wdata=%h busy=%b idx=%0d",
               i, req, full, gnt, ack, wr, wdata, busy, idx);
      chk($sformatf("row%0d", i), act, exp);
      @(posedge clk);
      #1;
    end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    chk("stall_cnt", {48'h0, stall_cnt}, 64'd5);
`endif

    // ---------------- Round robin, all four requesting ----------------
    do_reset();
    req  = 4'b1111;
    data = {12'h3C3, 12'h3C2, 12'h3C1, 12'h3C0};
    #3;
    chk("rr_first_idle", {60'h0, gnt}, 64'h0);
    @(posedge clk);
    #1;
    for (int b = 0; b < 5; b++) begin
      int g;
      g = b % 4;
      for (int beat = 0; beat < 4; beat++) begin
        #3;
        $display("rr burst %0d beat %0d: gnt=%b wr=%b wdata=%h", b, beat, gnt, wr, wdata);
        chk($sformatf("rr_b%0d_beat%0d", b, beat), {46'h0, gnt, wr, idx, wdata},
            {46'h0, 4'(1 << g), 1'b1, 2'(g), 12'(12'h3C0 + g)});
        @(posedge clk);
        #1;
      end
      #3;
      chk($sformatf("rr_b%0d_idle", b), {58'h0, gnt, wr, busy}, 64'h0);
      @(posedge clk);
      #1;
    end

    // ---------------- Asynchronous reset mid-burst ----------------
    do_reset();
    req  = 4'b0010;
    data = {12'h0, 12'h0E2, 12'h0E1, 12'h0};
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    req = 4'b0100;
    @(posedge clk);
    #1;
    req = 4'b1111;
    #2;
    chk("rst_pre_gnt", {59'h0, gnt, wr}, {59'h0, 4'b0100, 1'b1});
    #1;
    rst_n = 1'b0;
    #1;
    $display("async reset: gnt=%b busy=%b wr=%b", gnt, busy, wr);
    chk("rst_async_outputs", {58'h0, gnt, busy, wr}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    chk("rst_post_idle", {60'h0, gnt}, 64'h0);
    @(posedge clk);
    #4;
    chk("rst_post_grant", {58'h0, gnt, idx}, {58'h0, 4'b0001, 2'd0});
    @(posedge clk);
    #1;

    // ---------------- Integration with 16-deep FIFO ----------------
    do_reset();
    for (int k = 0; k < 4; k++) sent[k] = 0;
    fcnt = 0; n_wr = 0; ovf = 0; inv_bad = 0; hold_bad = 0;
    pend_wr = 0; pend_data = '0; pend_ack = '0; held = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (pend_wr) begin
        n_wr++;
        if (fcnt == 16) ovf = 1;
        else begin
          fmem[fcnt] = pend_data;
          fcnt++;
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (pend_ack[k]) sent[k]++;
      end
      full = (fcnt == 16);
      for (int k = 0; k < 4; k++) begin
        req[k] = (sent[k] < 10);
        data[k*12 +: 12] = 12'(k*256 + sent[k]);
      end
      #3;
      pend_wr   = wr;
      pend_data = wdata;
      pend_ack  = ack;
      if ($countones(ack) > 1) inv_bad = 1;
      if (wr && full) inv_bad = 1;
      if (full && gnt != 4'b0000) begin
        if (held == 4'b0000) held = gnt;
        else if (gnt != held) hold_bad = 1;
      end
      @(posedge clk);
      #1;
    end
    $display("integration: writes=%0d fifo_count=%0d overflow=%0d held_gnt=%b",
             n_wr, fcnt, ovf, held);
    chk("int_write_count", 64'(n_wr), 64'd16);
    chk("int_overflow", {63'h0, ovf}, 64'h0);
    chk("int_invariants", {63'h0, inv_bad}, 64'h0);
    chk("int_gnt_held", {63'h0, hold_bad}, 64'h0);
    chk("int_held_grantee", {59'h0, held, gnt == held}, {59'h0, 4'b0001, 1'b1});
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("int_fifo_word%0d", i), {52'h0, fmem[i]},
          {52'h0, 12'((i / 4) * 256 + (i % 4))});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin burst arbiter that shares the write port of one synchronous FIFO (write enable, write data, full flag) among NUM_REQ producers. It grants one producer at a time for a burst of up to BURST_LEN beats. It issues a write only when the FIFO is not full, so the FIFO overflow flag never asserts. It sits between the producer blocks and the FIFO write side; the read side is untouched.

Parameters:
NUM_REQ, 4, number of producers (2..8)
DATA_WIDTH, 12, FIFO word width
BURST_LEN, 4, maximum accepted beats per grant (1..255)
IDX_WIDTH, $clog2(NUM_REQ), width of the grant index

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
req_i  input  NUM_REQ  per-producer request/valid; producer holds its data while req is high
data_i  input  NUM_REQ*DATA_WIDTH  producer data; slice k = data_i[k*DATA_WIDTH +: DATA_WIDTH]
gnt_o  output  NUM_REQ  registered one-hot grant (all zero when idle)
ack_o  output  NUM_REQ  combinational; beat of producer k accepted this cycle
gnt_idx_o  output  IDX_WIDTH  registered index of the current grantee (holds its last value when idle)
busy_o  output  1  registered; high in BURST state
fifo_full_i  input  1  FIFO full flag
fifo_wr_en_o  output  1  FIFO write enable
fifo_wdata_o  output  DATA_WIDTH  FIFO write data

Behaviour:
- Reset (rst_ni low, asynchronous, mid-operation included): state=IDLE, gnt_o=0, gnt_idx_o=0, busy_o=0, beat_cnt=0, last_ptr=NUM_REQ-1 (producer 0 has highest first priority). Combinational outputs follow from this: ack_o=0, fifo_wr_en_o=0. An in-flight burst is abandoned and no write is issued.
- Accept rule (combinational): ack_o[k] = gnt_o[k] & req_i[k] & ~fifo_full_i. fifo_wr_en_o = |ack_o.
- fifo_wdata_o = data_i slice selected by gnt_idx_o. It is don't-care when fifo_wr_en_o=0, but it is driven from the index (no latch).
- FSM IDLE:
  - If |req_i, select the first requester found by searching from (last_ptr+1) mod NUM_REQ upward with wrap-around.
  - Register gnt_o/gnt_idx_o, clear beat_cnt, and go to BURST.
  - Otherwise stay in IDLE.
- FSM BURST, for grantee g, evaluated each cycle:
  - req_i[g]=0: release with no beat.
  - ack this cycle and beat_cnt==BURST_LEN-1: release after this beat.
  - ack this cycle otherwise: beat_cnt+1 and stay.
  - req_i[g]=1 and fifo_full_i=1: stall. Hold gnt_o, hold beat_cnt, no write, no timeout.
- Release: gnt_o<=0, busy_o<=0, last_ptr<=g, state<=IDLE.
  - There is always exactly one idle cycle between bursts.
  - The next grant therefore appears 2 cycles after the last beat of the previous burst.
- Latency: req_i rising in IDLE at cycle t gives gnt_o at t+1. The first ack/write is at t+1 if the FIFO is not full.
- Fairness: a continuously requesting producer waits at most (NUM_REQ-1)*(BURST_LEN+1) cycles plus FIFO-full stall cycles.
- Simultaneous events:
  - FIFO read in the same cycle as full: the arbiter sees fifo_full_i as given and only writes once full is low.
  - A non-granted req_i toggling mid-burst has no effect.
  - A producer dropping req_i in the same cycle its last beat would be accepted: no ack, and the burst is released.
- Width rules: beat_cnt is 8 bits. last_ptr and gnt_idx_o are IDX_WIDTH bits. The modulo wrap is explicit, so NUM_REQ need not be a power of two.
- Invariants: gnt_o is one-hot or zero. At most one ack_o bit is set. fifo_wr_en_o=1 implies fifo_full_i=0.

Optional Feature:
- Macro: FIFO_WR_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o, 16 bits, registered, reset to 0.
  - Increments in every BURST cycle where req_i[g]=1 and fifo_full_i=1.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Single producer, no other traffic: reset, req_i=4'b0010 held, data 12'h0A1..12'h0A6, FIFO not full.
  - gnt_o=0010 one cycle after req_i rises.
  - Writes 0A1..0A4 on 4 consecutive cycles, then gnt_o=0 for 1 cycle.
  - Re-grant of producer 1, writes 0A5, 0A6.
- All four requesting continuously, FIFO never full:
  - Grant order 0,1,2,3,0.
  - Each burst is exactly 4 writes followed by 1 idle cycle.
  - fifo_wdata_o matches the grantee's data every beat.
- Full stall: mid-burst after 2 beats, force fifo_full_i=1 for 5 cycles.
  - fifo_wr_en_o=0 and gnt_o held for those cycles.
  - After full is released, exactly 2 more beats, then release.
  - With the macro defined, stall_cnt_o=5.
- Early drop: producer 2 granted, drops req_i after 1 beat.
  - Burst ends with 1 write; next grant goes to producer 3 if requesting, otherwise wraps to 0.
- Reset mid-burst: assert rst_ni=0 asynchronously between clock edges during a beat.
  - gnt_o, busy_o, fifo_wr_en_o go to 0 immediately.
  - After release, with req_i=1111, the first grant goes to producer 0.
- Integration with a 16-deep, 12-bit synchronous FIFO, 4 producers each pushing 10 words, no reads:
  - Exactly 16 writes occur, the FIFO overflow flag never asserts, and gnt_o stays held while full.
